// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle MULT/MULTU/DIV/DIVU into HI/LO with a pipeline stall request.
// Optional MULDIV_FAST_MUL_EN: multiplies complete through a single-cycle multiplier.
module muldiv_unit #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic              cpu_clk_50M,
    input  logic              cpu_rst_n,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] src1,
    input  logic [DATA_W-1:0] src2,
    input  logic              flush,
    output logic              stallreq,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);
    localparam int W = DATA_W;
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t           state_q;
    logic             div_q, quo_neg_q, rem_neg_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]     opnd_q, hi_q, lo_q;
    logic [2*W-1:0]   acc_q, acc_d, mul_nxt, prod_fix;
    logic [W:0]       rem_q, rem_d, mul_sum;
    logic [W+1:0]     div_sub;
    logic [W-1:0]     abs1, abs2, quo_nxt, quo_fix, rem_fix;
    logic             is_signed, accept, div_zero, div_ok;
    assign is_signed = ~op[0];
    assign abs1      = (is_signed & src1[W-1]) ? -src1 : src1;
    assign abs2      = (is_signed & src2[W-1]) ? -src2 : src2;
    assign accept    = (state_q == IDLE) & start & ~flush;
    assign div_zero  = op[1] & (src2 == '0);
    // shift-add step: conditionally add the multiplicand to the upper half, then shift right
    assign mul_sum   = {1'b0, acc_q[2*W-1:W]} + {1'b0, acc_q[0] ? opnd_q : {W{1'b0}}};
    assign mul_nxt   = {mul_sum, acc_q[W-1:1]};
    // restoring step: the low half of acc shifts dividend bits out and quotient bits in
    assign div_sub   = {rem_q, acc_q[W-1]} - {2'b00, opnd_q};
    assign div_ok    = ~div_sub[W+1];
    assign rem_d     = div_ok ? div_sub[W:0] : {rem_q[W-1:0], acc_q[W-1]};
    assign quo_nxt   = {acc_q[W-2:0], div_ok};
    assign acc_d     = div_q ? {acc_q[2*W-1:W], quo_nxt} : mul_nxt;
    assign cnt_d     = cnt_q - 1'b1;
    assign prod_fix  = quo_neg_q ? -mul_nxt : mul_nxt;
    assign quo_fix   = quo_neg_q ? -quo_nxt : quo_nxt;
    assign rem_fix   = rem_neg_q ? -rem_d[W-1:0] : rem_d[W-1:0];
`ifdef MULDIV_FAST_MUL_EN
    logic [2*W-1:0] fast_raw, fast_prod;
    assign fast_raw  = {{W{1'b0}}, abs1} * {{W{1'b0}}, abs2};
    assign fast_prod = (is_signed & (src1[W-1] ^ src2[W-1])) ? -fast_raw : fast_raw;
`endif
    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            state_q   <= IDLE;
            div_q     <= 1'b0;
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            cnt_q     <= '0;
            opnd_q    <= '0;
            acc_q     <= '0;
            rem_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else if (flush) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE: if (accept) begin
                    div_q     <= op[1];
                    quo_neg_q <= is_signed & (src1[W-1] ^ src2[W-1]);
                    rem_neg_q <= is_signed & src1[W-1];
                    opnd_q    <= op[1] ? abs2 : abs1;
                    acc_q     <= {{W{1'b0}}, op[1] ? abs1 : abs2};
                    rem_q     <= '0;
                    cnt_q     <= CNT_W'(W);
                    if (div_zero) begin
                        state_q <= DONE;
                        hi_q    <= src1;
                        lo_q    <= '1;
                    end
`ifdef MULDIV_FAST_MUL_EN
                    else if (!op[1]) begin
                        state_q      <= DONE;
                        {hi_q, lo_q} <= fast_prod;
                    end
`endif
                    else begin
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    cnt_q <= cnt_d;
                    acc_q <= acc_d;
                    rem_q <= rem_d;
                    if (cnt_d == '0) begin
                        state_q      <= DONE;
                        {hi_q, lo_q} <= div_q ? {rem_fix, quo_fix} : prod_fix;
                    end
                end
                DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
    assign stallreq = accept | (state_q == CALC);
    assign busy     = state_q != IDLE;
    assign done     = state_q == DONE;
    assign hi       = hi_q;
    assign lo       = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: randomized and directed scoreboard bench for muldiv_unit against an arithmetic model.
module tb_muldiv_unit;
    logic        cpu_clk_50M = 1'b0;
    logic        cpu_rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] src1 = '0;
    logic [31:0] src2 = '0;
    logic        flush = 1'b0;
    logic        stallreq, busy, done;
    logic [31:0] hi, lo;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          n_chk = 0;
    int          n_pass = 0;
    logic [31:0] last_hi = '0;
    logic [31:0] last_lo = '0;

    muldiv_unit #(.DATA_W(32), .CNT_W(6)) dut (
        .cpu_clk_50M(cpu_clk_50M), .cpu_rst_n(cpu_rst_n), .start(start), .op(op),
        .src1(src1), .src2(src2), .flush(flush), .stallreq(stallreq), .busy(busy),
        .done(done), .hi(hi), .lo(lo)
    );

    always #10 cpu_clk_50M = ~cpu_clk_50M;
    always @(posedge cpu_clk_50M) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // reference: plain signed/unsigned arithmetic, result packed as {hi, lo}
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        int          sa, sb_;
        logic [31:0] q, r;
        sa = a;
        sb_ = b;
        if (o == 2'd0) return longint'(sa) * longint'(sb_);
        if (o == 2'd1) return 64'(a) * 64'(b);
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (o == 2'd2) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
            q = sa / sb_;
            r = sa % sb_;
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    function automatic int latency(input logic [1:0] o, input logic [31:0] b);
        if (o[1] && b == 0) return 1;
`ifdef MULDIV_FAST_MUL_EN
        if (!o[1]) return 1;
`endif
        return 33;
    endfunction

    function automatic logic [31:0] rv();
        case ($urandom_range(0, 6))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    always @(negedge cpu_clk_50M) begin
        if (cpu_rst_n && done) begin
            if (sb.size() == 0) chk("spurious_done", 64'(done), 64'd0);
            else begin
                exp_t e;
                e = sb.pop_front();
                chk("hi", 64'(hi), 64'(e.hi));
                chk("lo", 64'(lo), 64'(e.lo));
                chk("done_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    // called just after a rising edge; returns just after a rising edge with the unit idle
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] r;
        bit          seen;
        r = model(o, a, b);
        start = 1'b1;
        op = o;
        src1 = a;
        src2 = b;
        sb.push_back('{r[63:32], r[31:0], cyc + latency(o, b)});
        last_hi = r[63:32];
        last_lo = r[31:0];
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge cpu_clk_50M);
            if (done) begin
                seen = 1'b1;
                chk("stall_in_done", 64'(stallreq), 64'd0);
            end else chk("stall_while_busy", 64'(stallreq), 64'd1);
        end
        if (!seen) begin
            chk("done_timeout", 64'(done), 64'd1);
            sb.delete();
        end
        @(posedge cpu_clk_50M);
        #2 start = 1'b0;
        @(negedge cpu_clk_50M);
        chk("idle_after_done", 64'({done, busy, stallreq}), 64'd0);
        @(posedge cpu_clk_50M);
        #2;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge cpu_clk_50M);
        chk("reset_outputs", {hi, lo}, 64'd0);
        chk("reset_flags", 64'({done, busy, stallreq}), 64'd0);
        @(posedge cpu_clk_50M);
        #2 cpu_rst_n = 1'b1;
        @(posedge cpu_clk_50M);
        #2;
        run_op(2'd2, 32'hFFFF_FFF9, 32'd2);
        run_op(2'd3, 32'hFFFF_FFFF, 32'h10);
        run_op(2'd3, 32'd5, 32'd0);
        run_op(2'd0, 32'hFFFF_FFFD, 32'd4);
        run_op(2'd1, 32'hFFFF_FFFD, 32'd4);
        run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(2'd2, 32'd9, 32'd0);
        // flush mid-divide: no result, hi/lo keep the last completed values
        start = 1'b1;
        op = 2'd2;
        src1 = $urandom;
        src2 = $urandom | 32'd1;
        repeat (10) begin
            @(posedge cpu_clk_50M);
            #2;
        end
        flush = 1'b1;
        @(posedge cpu_clk_50M);
        #2 flush = 1'b0;
        start = 1'b0;
        @(negedge cpu_clk_50M);
        chk("flush_idle", 64'({busy, stallreq}), 64'd0);
        chk("flush_hilo", {hi, lo}, {last_hi, last_lo});
        @(posedge cpu_clk_50M);
        #2;
        run_op(2'd3, 32'd100, 32'd7);
        for (int i = 0; i < 30; i++) run_op(2'($urandom_range(0, 3)), rv(), rv());
        // asynchronous reset in the middle of a divide
        start = 1'b1;
        op = 2'd3;
        src1 = $urandom;
        src2 = $urandom | 32'd1;
        repeat (5) begin
            @(posedge cpu_clk_50M);
            #2;
        end
        cpu_rst_n = 1'b0;
        start = 1'b0;
        #1;
        chk("async_reset_hilo", {hi, lo}, 64'd0);
        chk("async_reset_flags", 64'({done, busy, stallreq}), 64'd0);
        @(posedge cpu_clk_50M);
        #2 cpu_rst_n = 1'b1;
        @(posedge cpu_clk_50M);
        #2;
        run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
